// File: rtl/apb_requester.sv
// APB initiator: one valid/ready command becomes one SETUP+ACCESS transfer, answered on a valid/ready response port.
// Optional ACCESS watchdog enabled by defining APB_REQ_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module apb_requester #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   padd,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic [1:0]          dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   padd_q, padd_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
  // valid never waits on ready, and the response payload is held until its beat transfers.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    padd_d      = padd_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_REQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          padd_d      = cmd_addr;
          pwdata_d    = cmd_wdata;
          pstrb_d     = cmd_write ? cmd_strb : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ST_ACCESS: begin
        // A completer answer on the limit edge takes priority over the watchdog.
        if (pready) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
`ifdef APB_REQ_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      padd_q      <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      padd_q      <= padd_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_REQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign padd      = padd_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;
`ifdef APB_REQ_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed and randomized transfers against a transaction-level response model.
// Honours APB_REQ_TIMEOUT_EN the same way the design does (limit TO cycles).
module tb_apb_requester;

  localparam int TO    = 8;
  localparam int RSP_W = 34;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] padd, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [RSP_W-1:0] exp_q[$];

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .padd(padd),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=sim_time_limit exp=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Drive one command through accept, SETUP, ACCESS (waits low-pready cycles first), and response.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd, input int waits,
                        input bit slverr, input int hold);
    bit               to;
    int               n_acc;
    int               n;
    logic [3:0]       exp_strb;
    logic [RSP_W-1:0] got;
    to = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
    if (waits >= TO) to = 1'b1;
`endif
    n_acc    = to ? TO : waits + 1;
    exp_strb = w ? s : 4'h0;
    exp_q.push_back({to, to | slverr, (to || w) ? 32'h0 : rd});

    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_wait", {63'h0, n < 20}, 64'h1);
    tick();
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom; cmd_strb = 4'($urandom);

    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    tick();

    for (int i = 0; i < n_acc; i++) begin
      check("acc_psel", psel, 1'b1);
      check("acc_penable", penable, 1'b1);
      check("acc_padd", padd, a);
      check("acc_pwrite", pwrite, w);
      check("acc_pwdata", pwdata, d);
      check("acc_pstrb", pstrb, exp_strb);
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : $urandom;
      pslverr = (i == waits) ? slverr : 1'($urandom);
      tick();
    end
    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;

    check("done_psel", psel, 1'b0);
    check("done_penable", penable, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'($urandom);
    for (int j = 0; j <= hold; j++) begin
      got = {rsp_timeout, rsp_err, rsp_rdata};
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_data", got, exp_q[0]);
      check("rsp_cmd_ready", cmd_ready, 1'b0);
      if (j == hold) rsp_ready = 1'b1;
      tick();
    end
    void'(exp_q.pop_front());
    rsp_ready = 1'b0;
    check("consume_rsp_valid", rsp_valid, 1'b0);
    check("consume_cmd_ready", cmd_ready, 1'b1);
    check("no_accept_on_consume", psel, 1'b0);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_padd", padd, 32'h0);
    rst = 1'b0;
    tick();

    do_txn(1'b1, 32'h10, 32'hA5, 4'b0001, 32'hDEAD_BEEF, 0, 1'b0, 0);
    do_txn(1'b0, 32'h14, 32'h1234_5678, 4'hF, 32'h0000_005A, 3, 1'b0, 0);
    do_txn(1'b1, 32'h20, 32'hCAFE_0001, 4'h0, 32'h0, 1, 1'b1, 0);
    do_txn(1'b0, 32'h24, 32'h0, 4'h3, 32'h8765_4321, 0, 1'b1, 5);

    for (int k = 0; k < 24; k++)
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
             $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));

    do_txn(1'b0, 32'h30, 32'h0, 4'h0, 32'h0BAD_F00D, TO - 1, 1'b0, 0);
    do_txn(1'b0, 32'h34, 32'h0, 4'h0, 32'h1111_2222, TO, 1'b0, 1);
    do_txn(1'b1, 32'h38, 32'h55, 4'hF, 32'h0, 1000, 1'b0, 0);

    // asynchronous reset while the transfer sits in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_penable", penable, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_psel", psel, 1'b0);
    check("arst_penable", penable, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_cmd_ready", cmd_ready, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 32'hA5A5_5A5A, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
